// File: rtl/ddr3_app_pkg.sv
// ddr3_app_pkg: shared constants and types for the DDR3 app-interface responder.
//   CMD_WRITE / CMD_READ : app_cmd encodings that are executed (others are dropped)
//   ADDR_LSB             : lowest app_addr bit that forms the word index
//   cmd_entry_t          : command FIFO entry {is_write, idx}
package ddr3_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam int         ADDR_LSB  = 3;

    // Widest index the 30-bit byte-column address can carry; the top uses
    // only the low MEM_DEPTH_LOG2 bits.
    localparam int IDX_W = 30 - ADDR_LSB;

    typedef struct packed {
        logic             is_write;
        logic [IDX_W-1:0] idx;
    } cmd_entry_t;

endpackage

// File: rtl/sim_sync_fifo.sv
// sim_sync_fifo: single-clock FIFO with registered full/empty flags.
//   clk, rst_n          : clock, asynchronous active-low reset (clears pointers/flags)
//   push, push_data     : write side; push is ignored while full
//   pop, head_data      : read side; head_data shows the oldest entry, pop ignored while empty
//   full, empty         : registered status, updated from the next-state count
module sim_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      store [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  do_push;
    logic                  do_pop;

    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = store[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Flags come from count_nxt so a pop in the same cycle as full
    // does not make room until the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (DEPTH_LOG2+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr3_app_responder.sv
// ddr3_app_responder: stands in for the MIG core on the DDR3 app interface,
// backed by a small on-chip memory.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   app_cmd/app_addr/app_en/app_rdy : command channel (000 write, 001 read)
//   app_wdf_data/mask/wren/end/rdy  : write-data channel (mask bit 1 = keep byte)
//   app_rd_data/_valid/_end         : read return, fixed RD_LATENCY, no backpressure
//   init_calib_complete             : rises CALIB_CYCLES cycles after reset release
module ddr3_app_responder
    import ddr3_app_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int MEM_DEPTH_LOG2  = 10,
    parameter int RD_LATENCY      = 8,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int CALIB_CYCLES    = 64,
    parameter int RDY_PERIOD      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              app_cmd,
    input  logic [29:0]             app_addr,
    input  logic                    app_en,
    output logic                    app_rdy,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_end,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end,
    output logic                    init_calib_complete
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int WDF_W  = DATA_WIDTH + MASK_W;

    logic [31:0]               calib_cnt;
    logic                      calib_done;
    logic                      stall;
    logic                      cmd_push;
    logic                      cmd_full;
    logic                      cmd_empty;
    cmd_entry_t                push_entry;
    cmd_entry_t                cmd_head;
    logic                      wdf_full;
    logic                      wdf_empty;
    logic [WDF_W-1:0]          wdf_head;
    logic [DATA_WIDTH-1:0]     wdf_head_data;
    logic [MASK_W-1:0]         wdf_head_mask;
    logic [MEM_DEPTH_LOG2-1:0] head_idx;
    logic                      exec_rd;
    logic                      exec_wr;
    logic [DATA_WIDTH-1:0]     mem [1 << MEM_DEPTH_LOG2];
    logic [RD_LATENCY-1:0]     rd_vld_p;
    logic [DATA_WIDTH-1:0]     rd_data_p [RD_LATENCY];
    logic                      unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calib_cnt  <= '0;
            calib_done <= 1'b0;
        end else if (!calib_done) begin
            calib_cnt <= calib_cnt + 32'd1;
            if (calib_cnt + 32'd1 >= 32'(CALIB_CYCLES)) calib_done <= 1'b1;
        end
    end

    assign init_calib_complete = calib_done;

    generate
        if (RDY_PERIOD > 0) begin : g_stall
            logic [31:0] stall_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                                 stall_cnt <= '0;
                else if (stall_cnt == 32'(RDY_PERIOD - 1))  stall_cnt <= '0;
                else                                        stall_cnt <= stall_cnt + 32'd1;
            end
            assign stall = (stall_cnt == 32'(RDY_PERIOD - 1));
        end else begin : g_no_stall
            assign stall = 1'b0;
        end
    endgenerate

    assign app_rdy     = calib_done & ~cmd_full & ~stall;
    assign app_wdf_rdy = calib_done & ~wdf_full;

    // Unknown opcodes are handshaken but never enqueued.
    assign cmd_push   = app_en & app_rdy & ((app_cmd == CMD_WRITE) | (app_cmd == CMD_READ));
    assign push_entry = '{is_write: (app_cmd == CMD_WRITE),
                          idx:      IDX_W'(app_addr[MEM_DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB])};

    sim_sync_fifo #(
        .WIDTH      ($bits(cmd_entry_t)),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data (push_entry),
        .pop       (exec_rd | exec_wr),
        .head_data (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty)
    );

    sim_sync_fifo #(
        .WIDTH      (WDF_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_wdf_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (app_wdf_wren & app_wdf_rdy),
        .push_data ({app_wdf_mask, app_wdf_data}),
        .pop       (exec_wr),
        .head_data (wdf_head),
        .full      (wdf_full),
        .empty     (wdf_empty)
    );

    assign wdf_head_data = wdf_head[DATA_WIDTH-1:0];
    assign wdf_head_mask = wdf_head[WDF_W-1:DATA_WIDTH];
    assign head_idx      = cmd_head.idx[MEM_DEPTH_LOG2-1:0];

    // A write at the head without its data holds the whole queue.
    assign exec_rd = ~cmd_empty & ~cmd_head.is_write;
    assign exec_wr = ~cmd_empty &  cmd_head.is_write & ~wdf_empty;

    always_ff @(posedge clk) begin
        if (exec_wr) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wdf_head_mask[b]) mem[head_idx][b*8 +: 8] <= wdf_head_data[b*8 +: 8];
            end
        end
    end

    // Stage p0: memory read of the executing command; stages p1.. delay it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p <= '0;
            for (int s = 0; s < RD_LATENCY; s++) rd_data_p[s] <= '0;
        end else begin
            rd_vld_p[0]  <= exec_rd;
            rd_data_p[0] <= exec_rd ? mem[head_idx] : '0;
            for (int s = 1; s < RD_LATENCY; s++) begin
                rd_vld_p[s]  <= rd_vld_p[s-1];
                rd_data_p[s] <= rd_data_p[s-1];
            end
        end
    end

    assign app_rd_data       = rd_data_p[RD_LATENCY-1];
    assign app_rd_data_valid = rd_vld_p[RD_LATENCY-1];
    assign app_rd_data_end   = rd_vld_p[RD_LATENCY-1];

    assign unused_bits = &{1'b0, app_wdf_end, app_addr[29:MEM_DEPTH_LOG2+ADDR_LSB],
                           app_addr[ADDR_LSB-1:0], cmd_head.idx[IDX_W-1:MEM_DEPTH_LOG2]};

endmodule
